// File: rtl/dmem_banked.sv
// dmem_banked: byte-addressed data memory with two load/store ports (A, B)
// and one dword read-only port (C). One-cycle registered read latency,
// read-first on same-word collisions, and B wins over A when both stores
// hit the same byte. Contents are cleared by a sweep after every reset.
module dmem_banked #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 1024,
  parameter int AW    = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            init_busy,
  input  logic            a_req,
  input  logic            a_we,
  input  logic [1:0]      a_size,
  input  logic            a_uns,
  input  logic [AW-1:0]   a_addr,
  input  logic [XLEN-1:0] a_wdata,
  output logic [XLEN-1:0] a_rdata,
  output logic            a_rvalid,
  output logic            a_fault,
  input  logic            b_req,
  input  logic            b_we,
  input  logic [1:0]      b_size,
  input  logic            b_uns,
  input  logic [AW-1:0]   b_addr,
  input  logic [XLEN-1:0] b_wdata,
  output logic [XLEN-1:0] b_rdata,
  output logic            b_rvalid,
  output logic            b_fault,
  input  logic            c_req,
  input  logic [AW-1:0]   c_addr,
  output logic [XLEN-1:0] c_rdata,
  output logic            c_rvalid,
  output logic            c_fault
);

  localparam int NB = XLEN / 8;
  localparam int LB = $clog2(NB);
  localparam int IW = $clog2(DEPTH);
  localparam logic [AW-1:0] LIMIT = AW'(DEPTH * NB);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t          state;
  logic [IW-1:0]   cnt;
  logic            busy_r;
  logic            run;

  logic [XLEN-1:0] mem [DEPTH];

  // Misalignment only depends on the low three address bits.
  function automatic logic misalign(input logic [2:0] lo, input logic [1:0] size);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return lo[0];
      2'b10:   return |lo[1:0];
      default: return |lo[2:0];
    endcase
  endfunction

  // Byte enables for an access of 2^size bytes starting at lane.
  function automatic logic [NB-1:0] lane_mask(input logic [1:0] size, input logic [LB-1:0] lane);
    logic [NB-1:0] m;
    m = '0;
    for (int i = 0; i < NB; i++)
      if (i < (1 << size)) m[i] = 1'b1;
    return m << lane;
  endfunction

  // Store data moved up to its byte lane; bytes outside the enables are ignored.
  function automatic logic [XLEN-1:0] lane_data(input logic [XLEN-1:0] wd, input logic [LB-1:0] lane);
    return wd << {lane, 3'b000};
  endfunction

  // Select the addressed bytes and sign- or zero-extend them.
  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] word, input logic [1:0] size,
                                               input logic [LB-1:0] lane, input logic uns);
    logic [XLEN-1:0] s;
    s = word >> {lane, 3'b000};
    case (size)
      2'b00:   return {{(XLEN-8){~uns & s[7]}},   s[7:0]};
      2'b01:   return {{(XLEN-16){~uns & s[15]}}, s[15:0]};
      2'b10:   return {{(XLEN-32){~uns & s[31]}}, s[31:0]};
      default: return s;
    endcase
  endfunction

  assign run       = (state == S_RUN);
  assign init_busy = busy_r;

  logic            a_bad, a_ld, a_st;
  logic [IW-1:0]   a_idx;
  logic [LB-1:0]   a_lane;
  logic [NB-1:0]   a_be;
  logic [XLEN-1:0] a_wd;

  assign a_bad  = misalign(a_addr[2:0], a_size) | (a_addr >= LIMIT);
  assign a_ld   = run & a_req & ~a_we & ~a_bad;
  assign a_st   = run & a_req & a_we & ~a_bad;
  assign a_idx  = a_addr[LB +: IW];
  assign a_lane = a_addr[LB-1:0];
  assign a_be   = a_st ? lane_mask(a_size, a_lane) : '0;
  assign a_wd   = lane_data(a_wdata, a_lane);

  logic            b_bad, b_ld, b_st;
  logic [IW-1:0]   b_idx;
  logic [LB-1:0]   b_lane;
  logic [NB-1:0]   b_be;
  logic [XLEN-1:0] b_wd;

  assign b_bad  = misalign(b_addr[2:0], b_size) | (b_addr >= LIMIT);
  assign b_ld   = run & b_req & ~b_we & ~b_bad;
  assign b_st   = run & b_req & b_we & ~b_bad;
  assign b_idx  = b_addr[LB +: IW];
  assign b_lane = b_addr[LB-1:0];
  assign b_be   = b_st ? lane_mask(b_size, b_lane) : '0;
  assign b_wd   = lane_data(b_wdata, b_lane);

  logic            c_bad, c_ld;
  logic [IW-1:0]   c_idx;

  assign c_bad = (|c_addr[LB-1:0]) | (c_addr >= LIMIT);
  assign c_ld  = run & c_req & ~c_bad;
  assign c_idx = c_addr[LB +: IW];

  // Init/run FSM: sweep counter walks every word once after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_INIT;
      cnt    <= '0;
      busy_r <= 1'b1;
    end else begin
      case (state)
        S_INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == IW'(DEPTH - 1)) begin
            state  <= S_RUN;
            busy_r <= 1'b0;
          end
        end
        default: state <= S_RUN;
      endcase
    end
  end

  // RAM write: sweep zeroes during init; B is written after A so B wins shared bytes.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[cnt] <= '0;
    end else begin
      for (int l = 0; l < NB; l++) begin
        if (a_be[l]) mem[a_idx][8*l +: 8] <= a_wd[8*l +: 8];
        if (b_be[l]) mem[b_idx][8*l +: 8] <= b_wd[8*l +: 8];
      end
    end
  end

  // ---- stage p1: registered responses (read-first against same-cycle stores)
  logic [XLEN-1:0] a_rdata_p1, b_rdata_p1, c_rdata_p1;
  logic            a_vld_p1, b_vld_p1, c_vld_p1;
  logic            a_flt_p1, b_flt_p1, c_flt_p1;

  // Port A response register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rdata_p1 <= '0;
      a_vld_p1   <= 1'b0;
      a_flt_p1   <= 1'b0;
    end else begin
      a_vld_p1 <= a_ld;
      a_flt_p1 <= run & a_req & a_bad;
      if (a_ld) a_rdata_p1 <= load_ext(mem[a_idx], a_size, a_lane, a_uns);
    end
  end

  // Port B response register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_rdata_p1 <= '0;
      b_vld_p1   <= 1'b0;
      b_flt_p1   <= 1'b0;
    end else begin
      b_vld_p1 <= b_ld;
      b_flt_p1 <= run & b_req & b_bad;
      if (b_ld) b_rdata_p1 <= load_ext(mem[b_idx], b_size, b_lane, b_uns);
    end
  end

  // Port C response register (always a full word).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_rdata_p1 <= '0;
      c_vld_p1   <= 1'b0;
      c_flt_p1   <= 1'b0;
    end else begin
      c_vld_p1 <= c_ld;
      c_flt_p1 <= run & c_req & c_bad;
      if (c_ld) c_rdata_p1 <= mem[c_idx];
    end
  end

  assign a_rdata  = a_rdata_p1;
  assign a_rvalid = a_vld_p1;
  assign a_fault  = a_flt_p1;
  assign b_rdata  = b_rdata_p1;
  assign b_rvalid = b_vld_p1;
  assign b_fault  = b_flt_p1;
  assign c_rdata  = c_rdata_p1;
  assign c_rvalid = c_vld_p1;
  assign c_fault  = c_flt_p1;

endmodule
